// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment codes are active-low, ordered {dp,g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg_scan_display_if.sv
// Load/display bundle for seg_scan_display.
// Optional SEG_BLINK_EN adds the per-digit blink mask.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
`ifdef SEG_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink_in;
`endif
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    upd_pending;
    logic                    frame_done;

    modport master (
        output load, digits_in, dp_in, blank_in,
`ifdef SEG_BLINK_EN
        output blink_in,
`endif
        input  seg_out, an_out, upd_pending, frame_done
    );

    modport slave (
        input  load, digits_in, dp_in, blank_in,
`ifdef SEG_BLINK_EN
        input  blink_in,
`endif
        output seg_out, an_out, upd_pending, frame_done
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Hex digit to active-low 7-segment code, optional decimal point.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] val_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = HEX_SEG[val_i];
        if (dp_i) seg_o[SEG_DP] = 1'b0;
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode 7-segment scanner with frame-atomic commit.
// Define SEG_BLINK_EN to add the blink mask and BLINK_FRAMES phase counter.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD_CYCLES = 2
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input logic clk,
    input logic rst,
    seg_scan_display_if.slave bus
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] GUARD   = CW'(GUARD_CYCLES);

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] dig;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      bl;
`ifdef SEG_BLINK_EN
        logic [NUM_DIGITS-1:0]      bk;
`endif
    } set_t;

    set_t                  act_q, act_d, pnd_q, pnd_d, in_set;
    logic                  upd_q, upd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  fd_q, fd_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            dec_seg;
    logic                  wrap_slot, wrap_frame, dark;

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
`endif

    seg_hex_decode u_dec (
        .val_i (act_q.dig[idx_q]),
        .dp_i  (act_q.dp[idx_q]),
        .seg_o (dec_seg)
    );

    always_comb begin
        in_set     = '0;
        in_set.dig = bus.digits_in;
        in_set.dp  = bus.dp_in;
        in_set.bl  = bus.blank_in;
`ifdef SEG_BLINK_EN
        in_set.bk  = bus.blink_in;
`endif

        wrap_slot  = (cnt_q == CNT_MAX);
        wrap_frame = wrap_slot && (idx_q == IDX_MAX);
        cnt_d      = wrap_slot ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        if (wrap_slot) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        // High during the final cycle of the last slot, i.e. the commit cycle
        fd_d = (cnt_d == CNT_MAX) && (idx_d == IDX_MAX);

        pnd_d = pnd_q;
        act_d = act_q;
        upd_d = upd_q;
        if (bus.load) begin
            pnd_d = in_set;
            upd_d = 1'b1;
        end
        if (wrap_frame) begin
            if (bus.load) begin
                act_d = in_set;
                upd_d = 1'b0;
            end else if (upd_q) begin
                act_d = pnd_q;
                upd_d = 1'b0;
            end
        end

        dark = act_q.bl[idx_q];
`ifdef SEG_BLINK_EN
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (wrap_frame) begin
            bcnt_d = (bcnt_q == BLK_MAX) ? '0 : bcnt_q + 1'b1;
            if (bcnt_q == BLK_MAX) phase_d = ~phase_q;
        end
        dark = dark | (phase_q & act_q.bk[idx_q]);
`endif

        seg_d = SEG_OFF;
        an_d  = '1;
        if (!(((GUARD_CYCLES > 0) && (cnt_q < GUARD)) || dark)) begin
            seg_d        = dec_seg;
            an_d[idx_q]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q    <= '0;
            act_q.bl <= '1;
            pnd_q    <= '0;
            pnd_q.bl <= '1;
            upd_q    <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            fd_q     <= 1'b0;
            seg_q    <= SEG_OFF;
            an_q     <= '1;
`ifdef SEG_BLINK_EN
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
`endif
        end else begin
            act_q    <= act_d;
            pnd_q    <= pnd_d;
            upd_q    <= upd_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            fd_q     <= fd_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
`ifdef SEG_BLINK_EN
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
`endif
        end
    end

    assign bus.seg_out     = seg_q;
    assign bus.an_out      = an_q;
    assign bus.upd_pending = upd_q;
    assign bus.frame_done  = fd_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: vector table, corner sequences and a
// cycle-level reference model driven by random loads (4 digits, 4-cycle slots).
module tb_seg_scan_display;

    localparam int N     = 4;
    localparam int S     = 4;
    localparam int G     = 1;
    localparam int FRAME = N * S;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_display_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_display #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (S),
        .GUARD_CYCLES (G)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] hexc [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Reference state: what is on display and what waits for the boundary
    int         cyc;
    logic [15:0] a_dig, p_dig;
    logic [3:0]  a_dp, a_bl, p_dp, p_bl;
    bit          m_upd;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic [31:0] seg;
        logic [15:0] an;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc   = 0;
        a_dig = '0; a_dp = '0; a_bl = 4'hF;
        p_dig = '0; p_dp = '0; p_bl = 4'hF;
        m_upd = 1'b0;
    endtask

    function automatic void exp_out(input int p, output logic [7:0] s,
                                    output logic [3:0] a);
        int i;
        int o;
        logic [3:0] d;
        i = p / S;
        o = p % S;
        d = a_dig[i*4 +: 4];
        if (o < G || a_bl[i]) begin
            s = 8'hFF;
            a = 4'hF;
        end else begin
            s = hexc[d];
            if (a_dp[i]) s = s & 8'h7F;
            a = 4'hF ^ (4'h1 << i);
        end
    endfunction

    task automatic tick();
        int         p;
        logic [7:0] es;
        logic [3:0] ea;
        bit         fe, old_upd, efd;
        logic [15:0] od;
        logic [3:0]  odp, obl;
        p = cyc % FRAME;
        exp_out(p, es, ea);
        fe = (p == FRAME - 1);
        old_upd = m_upd;
        od = p_dig; odp = p_dp; obl = p_bl;
        if (bus.load) begin
            p_dig = bus.digits_in; p_dp = bus.dp_in; p_bl = bus.blank_in;
            m_upd = 1'b1;
        end
        if (fe) begin
            if (bus.load) begin
                a_dig = bus.digits_in; a_dp = bus.dp_in; a_bl = bus.blank_in;
                m_upd = 1'b0;
            end else if (old_upd) begin
                a_dig = od; a_dp = odp; a_bl = obl;
                m_upd = 1'b0;
            end
        end
        cyc++;
        efd = ((cyc % FRAME) == FRAME - 1);
        @(posedge clk);
        #1;
        check("cycle", 32'({bus.seg_out, bus.an_out, bus.upd_pending,
                            bus.frame_done}),
              32'({es, ea, m_upd, efd}));
        bus.load = 1'b0;
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] dp,
                          input logic [3:0] bl);
        bus.digits_in = d;
        bus.dp_in     = dp;
        bus.blank_in  = bl;
        bus.load      = 1'b1;
    endtask

    task automatic wait_fd(input string nm);
        int b;
        b = 0;
        while (!bus.frame_done && b < 3 * FRAME) begin
            tick();
            b++;
        end
        check(nm, 32'(bus.frame_done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int first, bad, hits;

        tbl[0] = '{16'h3A90, 4'h0, 4'h0, 32'hB0_88_90_C0, 16'h7BDE};
        tbl[1] = '{16'h3A90, 4'h4, 4'h1, 32'hB0_08_90_FF, 16'h7BDF};
        tbl[2] = '{16'h7654, 4'hF, 4'h0, 32'h78_02_12_19, 16'h7BDE};
        tbl[3] = '{16'hBCDE, 4'h0, 4'hA, 32'hFF_C6_FF_86, 16'hFBFE};
        tbl[4] = '{16'h18F2, 4'h1, 4'h0, 32'hF9_80_8E_24, 16'h7BDE};

        bus.load = 1'b0;
        bus.digits_in = '0;
        bus.dp_in = '0;
        bus.blank_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", 32'(bus.seg_out), 32'hFF);
        check("rst_an", 32'(bus.an_out), 32'hF);
        check("rst_upd", 32'(bus.upd_pending), 32'd0);
        check("rst_fd", 32'(bus.frame_done), 32'd0);
        rst = 1'b1;

        first = -1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.frame_done && first < 0) first = k + 1;
            if (bus.seg_out != 8'hFF || bus.an_out != 4'hF) bad++;
        end
        check("fd_first_edge", 32'(first), 32'd15);
        check("dark_before_commit", 32'(bad), 32'd0);

        for (int v = 0; v < 5; v++) begin
            set_in(tbl[v].dig, tbl[v].dp, tbl[v].bl);
            tick();
            check($sformatf("v%0d_upd", v), 32'(bus.upd_pending), 32'd1);
            wait_fd($sformatf("v%0d_fd", v));
            tick();
            tick();
            check($sformatf("v%0d_guard", v),
                  32'({bus.seg_out, bus.an_out}), 32'h0FFF);
            tick();
            for (int i = 0; i < N; i++) begin
                if (i > 0) repeat (S) tick();
                check($sformatf("v%0d_seg%0d", v, i),
                      32'(bus.seg_out), 32'(tbl[v].seg[8*i +: 8]));
                check($sformatf("v%0d_an%0d", v, i),
                      32'(bus.an_out), 32'(tbl[v].an[4*i +: 4]));
            end
        end

        // Two loads in one frame: only the second may ever reach the display
        tick();
        tick();
        set_in(16'h1111, 4'h0, 4'h0);
        tick();
        tick();
        tick();
        set_in(16'h2222, 4'h0, 4'h0);
        tick();
        bad = 0;
        for (int b = 0; b < 3 * FRAME && !bus.frame_done; b++) begin
            if (!bus.upd_pending) bad++;
            tick();
        end
        if (!bus.upd_pending) bad++;
        check("dbl_upd_held", 32'(bad), 32'd0);
        tick();
        check("dbl_upd_clear", 32'(bus.upd_pending), 32'd0);
        bad = 0;
        hits = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (bus.seg_out == 8'hA4) hits++;
            else if (bus.seg_out != 8'hFF) bad++;
        end
        check("dbl_other", 32'(bad), 32'd0);
        check("dbl_a4_count", 32'(hits), 32'd12);

        // Load coinciding with the frame boundary goes straight to active
        wait_fd("byp_fd");
        set_in(16'hFFFF, 4'h0, 4'h0);
        tick();
        check("byp_upd", 32'(bus.upd_pending), 32'd0);
        bad = 0;
        hits = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (bus.seg_out == 8'h8E) hits++;
            else if (bus.seg_out != 8'hFF) bad++;
        end
        check("byp_other", 32'(bad), 32'd0);
        check("byp_8e_count", 32'(hits), 32'd12);

        // Reset mid-frame with a load pending
        set_in(16'h5555, 4'h0, 4'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_seg", 32'(bus.seg_out), 32'hFF);
        check("mid_rst_an", 32'(bus.an_out), 32'hF);
        check("mid_rst_upd", 32'(bus.upd_pending), 32'd0);
        check("mid_rst_fd", 32'(bus.frame_done), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2 * FRAME) tick();

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0)
                set_in(16'($urandom), 4'($urandom), 4'($urandom));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
